// File: rtl/flex_counter_ud.sv
// Up/down counter with parallel load, enable prescaler, wrap-or-saturate mode
// and a one-cycle wrap pulse. All outputs are registered.
module flex_counter_ud #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     count_enable,
  input  logic                     count_up,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  input  logic                     sat_mode,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     wrap_pulse
);

  localparam logic [NUM_CNT_BITS-1:0]  CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE  = NUM_CNT_BITS'(1);
  localparam logic [PRESCALE_BITS-1:0] PRE_ZERO = '0;
  localparam logic [PRESCALE_BITS-1:0] PRE_ONE  = PRESCALE_BITS'(1);

  logic [NUM_CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [PRESCALE_BITS-1:0] pre_q, pre_d;
  logic                     flag_q, flag_d;
  logic                     pulse_q, pulse_d;

  logic                     tick;
  logic [NUM_CNT_BITS-1:0]  step_cnt;
  logic                     step_wrap;
  logic [NUM_CNT_BITS-1:0]  terminal;

  // >= rather than == so lowering prescale_val below pre_q ticks on the next enabled cycle.
  assign tick     = count_enable && (pre_q >= prescale_val);
  assign terminal = count_up ? rollover_val : CNT_ONE;

  // Value the counter takes if a step happens this cycle.
  always_comb begin
    step_cnt  = cnt_q;
    step_wrap = 1'b0;
    if (rollover_val == CNT_ZERO) begin
      step_cnt = CNT_ZERO;
    end else if (count_up) begin
      if (cnt_q >= rollover_val) begin
        step_cnt  = sat_mode ? rollover_val : CNT_ONE;
        step_wrap = !sat_mode;
      end else begin
        step_cnt = cnt_q + CNT_ONE;
      end
    end else begin
      if (cnt_q <= CNT_ONE) begin
        // Saturation only holds a count of 1; a count of 0 still jumps to rollover_val.
        if (sat_mode && (cnt_q == CNT_ONE)) begin
          step_cnt = cnt_q;
        end else begin
          step_cnt = rollover_val;
        end
        step_wrap = !sat_mode;
      end else begin
        step_cnt = cnt_q - CNT_ONE;
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    pulse_d = 1'b0;
    if (clear) begin
      cnt_d = CNT_ZERO;
      pre_d = PRE_ZERO;
    end else if (load) begin
      cnt_d = load_val;
      pre_d = PRE_ZERO;
    end else if (tick) begin
      cnt_d   = step_cnt;
      pre_d   = PRE_ZERO;
      pulse_d = step_wrap;
    end else if (count_enable) begin
      pre_d = pre_q + PRE_ONE;
    end
    flag_d = !clear && (cnt_d == terminal) && (rollover_val != CNT_ZERO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= CNT_ZERO;
      pre_q   <= PRE_ZERO;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
    end
  end

  assign count_out     = cnt_q;
  assign rollover_flag = flag_q;
  assign wrap_pulse    = pulse_q;

endmodule

// File: tb/tb_flex_counter_ud.sv
// Directed-vector bench for flex_counter_ud; expected values are hand-computed.
module tb_flex_counter_ud;

  logic       clk = 1'b0;
  logic       rst, clear, count_enable, count_up, load, sat_mode;
  logic [3:0] load_val, rollover_val, prescale_val;
  logic [3:0] count_out;
  logic       rollover_flag, wrap_pulse;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  flex_counter_ud #(.NUM_CNT_BITS(4), .PRESCALE_BITS(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .count_enable(count_enable),
    .count_up(count_up), .load(load), .load_val(load_val),
    .rollover_val(rollover_val), .prescale_val(prescale_val), .sat_mode(sat_mode),
    .count_out(count_out), .rollover_flag(rollover_flag), .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One rising edge, then settle before sampling.
  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic f, input logic p);
    chk({tag, ".cnt"}, 32'(count_out), 32'(c));
    chk({tag, ".flag"}, 32'(rollover_flag), 32'(f));
    chk({tag, ".pulse"}, 32'(wrap_pulse), 32'(p));
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; count_enable = 1'b0; count_up = 1'b1; load = 1'b0;
    sat_mode = 1'b0; load_val = 4'd0; rollover_val = 4'd5; prescale_val = 4'd0;
    #2;
    tick_clk();
    chk_all("reset", 4'd0, 1'b0, 1'b0);

    // Basic up count with wrap.
    rst = 1'b0; count_enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick_clk();
      chk_all($sformatf("up5_%0d", i), 4'(i), (i == 5), 1'b0);
    end
    tick_clk();
    chk_all("up5_wrap", 4'd1, 1'b0, 1'b1);
    count_enable = 1'b0;
    tick_clk();
    chk_all("up5_hold", 4'd1, 1'b0, 1'b0);

    // Prescaler of 3.
    clear = 1'b1;
    tick_clk();
    chk_all("clear1", 4'd0, 1'b0, 1'b0);
    clear = 1'b0; rollover_val = 4'd4; prescale_val = 4'd2; count_enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick_clk();
      chk_all($sformatf("pre3_%0d", i), 4'(i / 3), (i == 12), 1'b0);
    end

    // Down count from a loaded value.
    count_enable = 1'b0; count_up = 1'b0; load = 1'b1; load_val = 4'd3;
    rollover_val = 4'd6; prescale_val = 4'd0;
    tick_clk();
    chk_all("dn_load", 4'd3, 1'b0, 1'b0);
    load = 1'b0; count_enable = 1'b1;
    tick_clk(); chk_all("dn_1", 4'd2, 1'b0, 1'b0);
    tick_clk(); chk_all("dn_2", 4'd1, 1'b1, 1'b0);
    tick_clk(); chk_all("dn_wrap", 4'd6, 1'b0, 1'b1);
    count_enable = 1'b0;
    tick_clk(); chk_all("dn_hold", 4'd6, 1'b0, 1'b0);

    // Saturating up then down.
    clear = 1'b1;
    tick_clk();
    clear = 1'b0; sat_mode = 1'b1; rollover_val = 4'd3; count_up = 1'b1; count_enable = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick_clk();
      chk_all($sformatf("sat_up_%0d", i), (i < 3) ? 4'(i) : 4'd3, (i >= 3), 1'b0);
    end
    count_up = 1'b0;
    tick_clk(); chk_all("sat_dn_1", 4'd2, 1'b0, 1'b0);
    tick_clk(); chk_all("sat_dn_2", 4'd1, 1'b1, 1'b0);
    tick_clk(); chk_all("sat_dn_3", 4'd1, 1'b1, 1'b0);

    // Direction change without a step re-evaluates the flag.
    sat_mode = 1'b0; count_enable = 1'b0; count_up = 1'b1;
    tick_clk(); chk_all("dir_flip", 4'd1, 1'b0, 1'b0);

    // Reset mid-count overrides clear, load and enable.
    clear = 1'b1;
    tick_clk();
    clear = 1'b0; prescale_val = 4'd2; count_enable = 1'b1;
    repeat (7) tick_clk();
    chk("mid_cnt", 32'(count_out), 32'd2);
    rst = 1'b1; load = 1'b1; clear = 1'b1; load_val = 4'd3;
    tick_clk();
    chk_all("mid_rst", 4'd0, 1'b0, 1'b0);
    rst = 1'b0; load = 1'b0; clear = 1'b0; prescale_val = 4'd0;
    tick_clk(); chk_all("post_rst", 4'd1, 1'b0, 1'b0);

    // Lowering prescale_val below the prescale count ticks next enabled cycle.
    prescale_val = 4'd3;
    tick_clk(); tick_clk();
    chk("pre_low_wait", 32'(count_out), 32'd1);
    prescale_val = 4'd1;
    tick_clk();
    chk("pre_low_tick", 32'(count_out), 32'd2);

    // Clear beats load; load outside the range then wraps on the next step.
    prescale_val = 4'd0; count_enable = 1'b0; clear = 1'b1; load = 1'b1; load_val = 4'd7;
    tick_clk(); chk_all("clr_load", 4'd0, 1'b0, 1'b0);
    clear = 1'b0; load_val = 4'd9; rollover_val = 4'd5;
    tick_clk(); chk_all("load9", 4'd9, 1'b0, 1'b0);
    load = 1'b0; count_enable = 1'b1;
    tick_clk(); chk_all("load9_wrap", 4'd1, 1'b0, 1'b1);

    // Down from zero wraps to rollover_val.
    count_enable = 1'b0; clear = 1'b1;
    tick_clk();
    clear = 1'b0; count_up = 1'b0; count_enable = 1'b1;
    tick_clk(); chk_all("dn_zero", 4'd5, 1'b0, 1'b1);

    // rollover_val of 0 forces 0 on every step.
    rollover_val = 4'd0;
    tick_clk(); chk_all("rv0", 4'd0, 1'b0, 1'b0);

    // Load wins over a simultaneous tick.
    rollover_val = 4'd5; count_up = 1'b1; load = 1'b1; load_val = 4'd5;
    tick_clk(); chk_all("load_tick", 4'd5, 1'b1, 1'b0);
    load = 1'b0;
    tick_clk(); chk_all("after_load", 4'd1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
